// File: rtl/mac_col_ctrl_if.sv
// Handshake and column-drive bundle between the feature/weight buffers, the
// column sequencer (slave side) and whoever supplies jobs (master side).
interface mac_col_ctrl_if #(
  parameter int CNT_W = 9
);
  logic             start;
  logic [CNT_W-1:0] cfg_len;
  logic [2:0]       cfg_rows;
  logic             w_valid;
  logic [7:0]       w_data;
  logic             w_ready;
  logic             x_valid;
  logic [7:0]       x_data;
  logic             x_ready;
  logic             en_w_o;
  logic [7:0]       w_o;
  logic             en_x_o;
  logic [7:0]       x_o;
  logic             stop_mac_o;
  logic             used_row_o;
  logic             sum_valid_o;
  logic             sum_last_o;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  start, cfg_len, cfg_rows, w_valid, w_data, x_valid, x_data,
    output w_ready, x_ready, en_w_o, w_o, en_x_o, x_o, stop_mac_o, used_row_o,
           sum_valid_o, sum_last_o, busy, done, err
  );

  modport master (
    output start, cfg_len, cfg_rows, w_valid, w_data, x_valid, x_data,
    input  w_ready, x_ready, en_w_o, w_o, en_x_o, x_o, stop_mac_o, used_row_o,
           sum_valid_o, sum_last_o, busy, done, err
  );
endinterface

// File: rtl/mac_col_ctrl.sv
// Sequencer for one weight-stationary MAC column: weight load, activation stream,
// pipe flush and result tagging. Define MAC_COL_PERF_EN for the stall counter port.
module mac_col_ctrl #(
  parameter int ROWS  = 4,
  parameter int CNT_W = 9
) (
  input  logic          clk,
  input  logic          rst,
  mac_col_ctrl_if.slave bus
`ifdef MAC_COL_PERF_EN
  ,
  output logic [15:0]   perf_stall_cnt_o
`endif
);
  localparam int WCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [2:0]       rows_q, rows_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [WCW-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0] xcnt_q, xcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [ROWS-1:0]  tag_q, tag_d;
  logic [7:0]       w_hold_q, w_hold_d;
  logic [7:0]       x_hold_q, x_hold_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic       cfg_ok, start_ok, w_acc, x_acc, en_x, sum_valid;
  logic [2:0] row_idx;

  assign cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_rows != 3'd0) && (bus.cfg_rows <= 3'(ROWS));
  assign start_ok  = (state_q == S_IDLE) && bus.start && cfg_ok;
  assign w_acc     = (state_q == S_LOAD_W) && bus.w_valid;
  assign x_acc     = (state_q == S_STREAM) && bus.x_valid;
  assign en_x      = x_acc || (state_q == S_DRAIN);
  assign sum_valid = en_x && tag_q[ROWS-1];
  // The first weight accepted ends up in the bottom row, so it maps to row ROWS-1.
  assign row_idx   = 3'(ROWS-1) - 3'(wcnt_q);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rows_d   = rows_q;
    wcnt_d   = wcnt_q;
    dcnt_d   = dcnt_q;
    xcnt_d   = xcnt_q;
    rcnt_d   = rcnt_q;
    tag_d    = tag_q;
    w_hold_d = w_hold_q;
    x_hold_d = x_hold_q;
    busy_d   = busy_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_LOAD_W;
          len_d   = bus.cfg_len;
          rows_d  = bus.cfg_rows;
          wcnt_d  = '0;
          xcnt_d  = '0;
          rcnt_d  = '0;
          tag_d   = '0;
          busy_d  = 1'b1;
        end else if (bus.start) begin
          err_d = 1'b1;
        end
      end
      S_LOAD_W: begin
        if (w_acc) begin
          wcnt_d   = wcnt_q + WCW'(1);
          w_hold_d = bus.w_data;
          if (wcnt_q == WCW'(ROWS-1)) state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (x_acc) begin
          xcnt_d   = xcnt_q + CNT_W'(1);
          x_hold_d = bus.x_data;
          if (xcnt_q == len_q - CNT_W'(1)) begin
            state_d = S_DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + WCW'(1);
        if (dcnt_q == WCW'(ROWS-1)) state_d = S_FIN;
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Tags travel with the data through the column, so they only move on en_x beats.
    if (en_x) tag_d = {tag_q[ROWS-2:0], (state_q == S_STREAM)};
    if (sum_valid) rcnt_d = rcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      rows_q   <= '0;
      wcnt_q   <= '0;
      dcnt_q   <= '0;
      xcnt_q   <= '0;
      rcnt_q   <= '0;
      tag_q    <= '0;
      w_hold_q <= '0;
      x_hold_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rows_q   <= rows_d;
      wcnt_q   <= wcnt_d;
      dcnt_q   <= dcnt_d;
      xcnt_q   <= xcnt_d;
      rcnt_q   <= rcnt_d;
      tag_q    <= tag_d;
      w_hold_q <= w_hold_d;
      x_hold_q <= x_hold_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.w_ready     = (state_q == S_LOAD_W);
  assign bus.en_w_o      = w_acc;
  assign bus.w_o         = w_acc ? bus.w_data : w_hold_q;
  assign bus.used_row_o  = w_acc && (row_idx < rows_q);
  assign bus.x_ready     = (state_q == S_STREAM);
  assign bus.en_x_o      = en_x;
  assign bus.x_o         = x_acc ? bus.x_data : ((state_q == S_DRAIN) ? 8'd0 : x_hold_q);
  assign bus.stop_mac_o  = !((state_q == S_STREAM) || (state_q == S_DRAIN));
  assign bus.sum_valid_o = sum_valid;
  assign bus.sum_last_o  = sum_valid && (rcnt_q == len_q - CNT_W'(1));
  assign bus.busy        = busy_q;
  assign bus.done        = (state_q == S_FIN);
  assign bus.err         = err_q;

`ifdef MAC_COL_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok)
      stall_d = '0;
    else if ((state_q == S_STREAM) && !bus.x_valid && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign perf_stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_mac_col_ctrl.sv
// Scoreboard bench for mac_col_ctrl: expected weight/activation/result beats are
// queued as stimulus is driven and retired by a negedge monitor.
module tb_mac_col_ctrl;
  localparam int ROWS  = 4;
  localparam int CNT_W = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_col_ctrl_if #(.CNT_W(CNT_W)) bus ();
`ifdef MAC_COL_PERF_EN
  logic [15:0] perf;
`endif

  mac_col_ctrl #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MAC_COL_PERF_EN
    ,
    .perf_stall_cnt_o (perf)
`endif
  );

  typedef struct { logic [7:0] w; logic used; } wexp_t;
  typedef struct { int beat; logic last; } rexp_t;

  wexp_t      wq[$];
  logic [7:0] xq[$];
  rexp_t      rq[$];
  wexp_t      we;
  rexp_t      re;
  logic [7:0] xe;

  int errors = 0;
  int checks = 0;
  int beat = 0;
  int sum_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.en_w_o) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL en_w_spurious got w_o=%0d required no weight beat", bus.w_o);
        end else begin
          we = wq.pop_front();
          if (bus.w_o !== we.w || bus.used_row_o !== we.used) begin
            errors++;
            $display("FAIL weight_beat got w_o=%0d used_row=%0b required w_o=%0d used_row=%0b",
                     bus.w_o, bus.used_row_o, we.w, we.used);
          end
        end
      end
      if (bus.en_x_o) begin
        beat++;
        checks++;
        if (xq.size() == 0) begin
          errors++;
          $display("FAIL en_x_spurious got x_o=%0d required no activation beat", bus.x_o);
        end else begin
          xe = xq.pop_front();
          if (bus.x_o !== xe || bus.stop_mac_o !== 1'b0) begin
            errors++;
            $display("FAIL act_beat got x_o=%0d stop=%0b required x_o=%0d stop=0",
                     bus.x_o, bus.stop_mac_o, xe);
          end
        end
      end
      if (bus.sum_valid_o) begin
        sum_cnt++;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL sum_spurious got sum_valid at beat %0d required none", beat);
        end else begin
          re = rq.pop_front();
          if (beat !== re.beat || bus.sum_last_o !== re.last) begin
            errors++;
            $display("FAIL result_beat got beat=%0d last=%0b required beat=%0d last=%0b",
                     beat, bus.sum_last_o, re.beat, re.last);
          end
        end
      end else if (bus.sum_last_o) begin
        checks++;
        errors++;
        $display("FAIL sum_last_alone got sum_last=1 required 0 without sum_valid");
      end
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
    end
  end

  task automatic pulse_start(input int len, input int rows);
    bus.start    = 1'b1;
    bus.cfg_len  = CNT_W'(len);
    bus.cfg_rows = 3'(rows);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input bit is_w);
    int t = 0;
    @(negedge clk);
    while (!(is_w ? bus.w_ready : bus.x_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got ready=0 required ready=1 (weights=%0b)", is_w);
    end
    @(posedge clk); #1;
  endtask

  task automatic load_weights(input int rows, input int wbase);
    for (int i = 0; i < ROWS; i++) begin
      wq.push_back('{w: 8'(wbase + i), used: ((ROWS - 1 - i) < rows)});
      bus.w_valid = 1'b1;
      bus.w_data  = 8'(wbase + i);
      wait_ready(1'b1);
    end
    bus.w_valid = 1'b0;
  endtask

  task automatic stream_x(input int len, input int upto, input int stall_at, input int stall_n);
    for (int i = 0; i < upto; i++) begin
      if (i == stall_at) begin
        bus.x_valid = 1'b0;
        repeat (stall_n) begin @(posedge clk); #1; end
      end
      xq.push_back(8'(10 * (i + 1)));
      rq.push_back('{beat: i + 1 + ROWS, last: (i == len - 1)});
      bus.x_valid = 1'b1;
      bus.x_data  = 8'(10 * (i + 1));
      wait_ready(1'b0);
    end
    bus.x_valid = 1'b0;
  endtask

  task automatic run_job(input int len, input int rows, input int wbase,
                         input int stall_at, input int stall_n, input bit poke_drain);
    int  d0, e0, t;
    bit  seen;
    d0 = done_cnt;
    e0 = err_cnt;
    beat = 0;
    sum_cnt = 0;
    pulse_start(len, rows);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_set got %0b required 1", bus.busy);
    end
    load_weights(rows, wbase);
    stream_x(len, len, stall_at, stall_n);
    repeat (ROWS) xq.push_back(8'd0);
    if (poke_drain) pulse_start(5, 2);
    seen = 1'b0;
    t = 0;
    while (!seen && t < 40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      t++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got no done required done within 40 cycles");
    end
    checks++;
    if (beat !== len + ROWS) begin
      errors++;
      $display("FAIL beats_at_done got %0d required %0d", beat, len + ROWS);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL after_done got busy=%0b done=%0b required 0 0", bus.busy, bus.done);
    end
    checks++;
    if (sum_cnt !== len || done_cnt !== d0 + 1 || err_cnt !== e0) begin
      errors++;
      $display("FAIL job_counts got sums=%0d dones=%0d errs=%0d required %0d 1 0",
               sum_cnt, done_cnt - d0, err_cnt - e0, len);
    end
    checks++;
    if (wq.size() != 0 || xq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL queues_left got w=%0d x=%0d r=%0d required 0 0 0",
               wq.size(), xq.size(), rq.size());
    end
`ifdef MAC_COL_PERF_EN
    checks++;
    if (perf !== 16'((stall_at < len) ? stall_n : 0)) begin
      errors++;
      $display("FAIL perf_stall got %0d required %0d", perf, (stall_at < len) ? stall_n : 0);
    end
`endif
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (bus.busy !== 1'b0 || bus.w_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_job got busy=%0b w_ready=%0b required 0 0", bus.busy, bus.w_ready);
    end
    $display("job len=%0d rows=%0d stall=%0d poke=%0b finished after %0d beats",
             len, rows, stall_n, poke_drain, beat);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (bus.stop_mac_o !== 1'b1 || bus.busy !== 1'b0 || bus.w_ready !== 1'b0 ||
        bus.x_ready !== 1'b0 || bus.en_w_o !== 1'b0 || bus.en_x_o !== 1'b0 ||
        bus.sum_valid_o !== 1'b0 || bus.sum_last_o !== 1'b0 || bus.done !== 1'b0 ||
        bus.err !== 1'b0 || bus.used_row_o !== 1'b0) begin
      errors++;
      $display("FAIL %s got stop=%0b busy=%0b wr=%0b xr=%0b enw=%0b enx=%0b sv=%0b sl=%0b done=%0b err=%0b required 1 0 0 0 0 0 0 0 0 0",
               tag, bus.stop_mac_o, bus.busy, bus.w_ready, bus.x_ready, bus.en_w_o,
               bus.en_x_o, bus.sum_valid_o, bus.sum_last_o, bus.done, bus.err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_rows = '0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.x_valid = 1'b0; bus.x_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_bad_cfg(input int len, input int rows);
    int e0 = err_cnt;
    pulse_start(len, rows);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.w_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_cfg_pulse len=%0d rows=%0d got err=%0b busy=%0b w_ready=%0b required 1 0 0",
               len, rows, bus.err, bus.busy, bus.w_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.w_ready !== 1'b0 || err_cnt !== e0 + 1) begin
      errors++;
      $display("FAIL bad_cfg_after got err=%0b busy=%0b w_ready=%0b pulses=%0d required 0 0 0 1",
               bus.err, bus.busy, bus.w_ready, err_cnt - e0);
    end
    $display("bad start len=%0d rows=%0d rejected", len, rows);
  endtask

  task automatic test_reset_midstream();
    int d0;
    beat = 0;
    pulse_start(6, 4);
    load_weights(4, 7);
    stream_x(6, 2, 99, 0);
    bus.x_valid = 1'b1;
    bus.x_data  = 8'd33;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_midstream");
    wq.delete(); xq.delete(); rq.delete();
    repeat (3) @(posedge clk);
    #1;
    bus.x_valid = 1'b0;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt !== d0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got dones=%0d busy=%0b required 0 0", done_cnt - d0, bus.busy);
    end
    $display("reset during stream abandoned job");
    run_job(6, 4, 1, 99, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    run_job(3, 4, 1, 99, 0, 1'b0);
    run_job(4, 2, -3, 99, 0, 1'b0);
    run_job(5, 4, 20, 2, 2, 1'b0);
    test_bad_cfg(0, 4);
    test_bad_cfg(3, 5);
    test_bad_cfg(3, 0);
    test_reset_midstream();
    run_job(3, 3, 5, 99, 0, 1'b1);
    run_job(2, 1, 100, 1, 3, 1'b0);
    run_job(7, 4, -100, 0, 1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
